// File: rtl/rv_imem_boot_pkg.sv
// Shared defaults and encodings for the boot-loaded instruction memory.
package rv_imem_boot_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ROM_DEPTH_DEF  = 64;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } boot_state_e;

  // Where instr_o currently comes from; lets the RAM read register stay reset-free.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_NOP  = 2'd2
  } instr_src_e;

endpackage

// File: rtl/rv_imem_ram.sv
// Instruction storage: one synchronous write port, one registered read port.
module rv_imem_ram
  import rv_imem_boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_imem_boot.sv
// Byte-serial program loader feeding an instruction ROM; releases the core
// reset once loading finishes and serves single-cycle-latency fetches.
module rv_imem_boot
  import rv_imem_boot_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned            ROM_DEPTH  = ROM_DEPTH_DEF,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEF),
  localparam int unsigned           ADDR_W     = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  core_rstn_o,
  output logic                  boot_done_o,
  input  logic                  instr_req_i,
  input  logic [ADDR_W-1:0]     instr_addr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  instr_valid_o
);

  localparam int unsigned       NBYTES    = DATA_WIDTH / 8;
  localparam int unsigned       BCNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(ROM_DEPTH - 1);

  boot_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       wcnt_q, wcnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  instr_src_e            src_q, src_d;
  logic                  valid_q;
  logic                  core_rstn_q;

  logic [DATA_WIDTH-1:0] word_merged;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic                  ram_re;
  logic                  fetch_en;
  logic                  addr_hit;

  // Unfilled lanes of asm_q are always zero, so a short final word is zero-padded for free.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign word_merged[gi*8 +: 8] = (bcnt_q == BCNT_W'(gi)) ? ld_data_i : asm_q[gi*8 +: 8];
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    src_d       = src_q;
    ram_we      = 1'b0;
    ld_ready_o  = (state_q == ST_LOAD);
    boot_done_o = (state_q == ST_RUN);

    if ((state_q == ST_LOAD) && ld_valid_i) begin
      if ((bcnt_q == BCNT_LAST) || ld_last_i) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        wcnt_d   = wcnt_q + 1'b1;
        bcnt_d   = '0;
        asm_d    = '0;
        if (ld_last_i || (wr_ptr_q == PTR_LAST)) begin
          state_d = ST_RUN;
        end
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        asm_d  = word_merged;
      end
    end

    // Addresses at or beyond wcnt were never loaded since reset and read as NOP.
    fetch_en = instr_req_i && (state_q == ST_RUN);
    addr_hit = ({1'b0, instr_addr_i} < wcnt_q);
    ram_re   = fetch_en && addr_hit;
    if (fetch_en) begin
      src_d = addr_hit ? SRC_RAM : SRC_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
      src_q       <= SRC_ZERO;
      valid_q     <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      src_q       <= src_d;
      valid_q     <= fetch_en;
      core_rstn_q <= core_rstn_q | (state_q == ST_RUN);
    end
  end

  rv_imem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (word_merged),
    .re_i    (ram_re),
    .raddr_i (instr_addr_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    case (src_q)
      SRC_RAM: instr_o = ram_rdata;
      SRC_NOP: instr_o = NOP_INSTR;
      default: instr_o = '0;
    endcase
  end

  assign instr_valid_o = valid_q;
  assign core_rstn_o   = core_rstn_q;

endmodule

// File: tb/tb_rv_imem_boot.sv
// Directed and randomized checks of rv_imem_boot against a byte-stream model.
module tb_rv_imem_boot;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        core_rstn_o;
  logic        boot_done_o;
  logic        instr_req_i;
  logic [1:0]  instr_addr_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;

  rv_imem_boot #(
    .DATA_WIDTH (32),
    .ROM_DEPTH  (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid_i    (ld_valid_i),
    .ld_data_i     (ld_data_i),
    .ld_last_i     (ld_last_i),
    .ld_ready_o    (ld_ready_o),
    .core_rstn_o   (core_rstn_o),
    .boot_done_o   (boot_done_o),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [7:0]  acc[$];          // bytes accepted since the last reset
  bit          in_load;
  logic [31:0] last_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word idx of the program image: little-endian bytes, zero-padded at the tail.
  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) begin
      if (idx * 4 + k < acc.size()) w = w | (32'(acc[idx*4+k]) << (8 * k));
    end
    return w;
  endfunction

  function automatic logic [31:0] model_fetch(input int addr);
    int wcnt = (acc.size() + 3) / 4;
    return (addr < wcnt) ? model_word(addr) : NOP;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0; ld_last_i = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = '0;
    step(); step();
    check("rst_boot_done", 32'(boot_done_o), 32'd0);
    check("rst_core_rstn", 32'(core_rstn_o), 32'd0);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    rst_n = 1'b1;
    check("rst_ld_ready", 32'(ld_ready_o), 32'd1);
    acc.delete();
    in_load = 1'b1;
    last_instr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input bit pulse, input int gap);
    bit was_load;
    repeat (gap) step();
    check("ld_ready", 32'(ld_ready_o), 32'(in_load));
    was_load = in_load;
    ld_valid_i = 1'b1; ld_data_i = b; ld_last_i = last;
    instr_req_i = pulse; instr_addr_i = 2'($urandom);
    step();
    ld_valid_i = 1'b0; ld_last_i = 1'b0; instr_req_i = 1'b0;
    if (was_load) begin
      acc.push_back(b);
      if (last || acc.size() == 4 * DEPTH) in_load = 1'b0;
    end
    if (pulse) check("load_req_ignored", 32'(instr_valid_o), 32'd0);
    check("boot_done", 32'(boot_done_o), 32'(!in_load));
    if (was_load && !in_load) begin
      check("core_rstn_lag", 32'(core_rstn_o), 32'd0);
      step();
      check("core_rstn_rise", 32'(core_rstn_o), 32'd1);
    end
  endtask

  // Leaves instr_req_i high so consecutive calls form back-to-back requests.
  task automatic fetch_chk(input int addr, input logic [31:0] exp, input string tag);
    instr_req_i = 1'b1; instr_addr_i = 2'(addr);
    step();
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    check(tag, instr_o, exp);
    last_instr = exp;
  endtask

  task automatic idle_chk();
    instr_req_i = 1'b0;
    step();
    check("idle_valid", 32'(instr_valid_o), 32'd0);
    check("idle_hold", instr_o, last_instr);
  endtask

  initial begin
    logic [7:0] prog[8];
    logic [7:0] rb;
    int n;
    bit lst;

    do_reset();

    // Two-word program, last flag on the eighth byte.
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, 1'b0, 0);
    fetch_chk(0, 32'h0050_0013, "fetch_a0");
    fetch_chk(1, 32'h0010_0093, "fetch_a1");
    fetch_chk(2, NOP, "fetch_a2_nop");
    idle_chk();

    // Partial final word is zero-padded.
    do_reset();
    send_byte(8'hAA, 1'b0, 1'b0, 0);
    send_byte(8'hBB, 1'b1, 1'b0, 1);
    fetch_chk(0, 32'h0000_BBAA, "partial_w0");
    fetch_chk(1, NOP, "partial_a1_nop");
    idle_chk();

    // Filling the whole ROM ends the load; requests during LOAD are ignored.
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'($urandom), 1'b0, (i % 3) == 0, 0);
    send_byte(8'h5A, 1'b1, 1'b0, 0);
    for (int a = 0; a < DEPTH; a++) fetch_chk(a, model_fetch(a), "full_fetch");
    idle_chk();

    // Reset from RUN, then a one-word reload masks the stale upper words.
    do_reset();
    send_byte(8'h93, 1'b0, 1'b0, 0);
    send_byte(8'h00, 1'b0, 1'b1, 0);
    send_byte(8'h00, 1'b0, 1'b0, 0);
    send_byte(8'h00, 1'b1, 1'b0, 0);
    fetch_chk(1, NOP, "reload_a1_nop");
    fetch_chk(0, 32'h0000_0093, "reload_a0");
    idle_chk();

    // Randomized programs, gaps, dropped trailing bytes and fetch patterns.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(1, 4 * DEPTH);
      for (int i = 0; i < n; i++) begin
        lst = (i == n - 1) && ((n < 4 * DEPTH) || $urandom_range(0, 1) == 1);
        send_byte(8'($urandom), lst, $urandom_range(0, 2) == 0, $urandom_range(0, 2));
      end
      repeat ($urandom_range(0, 2)) begin
        rb = 8'($urandom);
        send_byte(rb, 1'($urandom), 1'b0, 0);
      end
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          n = $urandom_range(0, DEPTH - 1);
          fetch_chk(n, model_fetch(n), "rand_fetch");
        end else begin
          idle_chk();
        end
      end
      instr_req_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
